// File: rtl/smart_mac_ctrl_pkg.sv
// Shared definitions for the smart MAC row controller: FSM state encodings
// and phase-length helpers, reused by the array top-level.
package smart_mac_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_COMPUTE = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    // Phase lengths in cycles; the counter is loaded with length - 1.
    function automatic int load_cycles(input int num_macs);
        return num_macs;
    endfunction

    function automatic int compute_cycles(input int len, input int num_macs);
        return len + num_macs - 1;
    endfunction

endpackage

// File: rtl/smart_mac_ctrl_if.sv
// Job handshake, configuration and MAC-row control bundle between the array
// top-level (master) and the row controller (slave).
interface smart_mac_ctrl_if #(
    parameter int NUM_MACS = 4,
    parameter int CNT_W    = 8
);
    logic                start;
    logic                abort;
    logic [CNT_W-1:0]    cfg_len;
    logic [NUM_MACS-1:0] cfg_top_mask;
    logic [NUM_MACS-1:0] cfg_route_mask;

    logic                busy;
    logic                done;
    logic                err;
    logic                feed_en;
    logic                fsm_op2_select;
    logic                fsm_out_select;
    logic                stat_bit;
    logic [NUM_MACS-1:0] select_top_in_smart;
    logic [NUM_MACS-1:0] select_right_out_smart;

    modport master (
        output start, abort, cfg_len, cfg_top_mask, cfg_route_mask,
        input  busy, done, err, feed_en, fsm_op2_select, fsm_out_select,
               stat_bit, select_top_in_smart, select_right_out_smart
    );

    modport slave (
        input  start, abort, cfg_len, cfg_top_mask, cfg_route_mask,
        output busy, done, err, feed_en, fsm_op2_select, fsm_out_select,
               stat_bit, select_top_in_smart, select_right_out_smart
    );
endinterface

// File: rtl/smart_mac_ctrl_phase_counter.sv
// Phase counter: loadable down-counter with zero flag; exposes its next value
// so the owner can register outputs that depend on the upcoming count.
module smart_mac_ctrl_phase_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count_next,
    output logic         zero
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_next = count_d;
    assign zero       = (count_q == '0);
endmodule

// File: rtl/smart_mac_ctrl.sv
// Row sequencer for NUM_MACS smart MAC units: LOAD stationary operands,
// skewed COMPUTE, DRAIN accumulators, with registered control outputs.
module smart_mac_ctrl
    import smart_mac_ctrl_pkg::*;
#(
    parameter int NUM_MACS = 4,
    parameter int CNT_W    = 8
) (
    input logic             clk,
    input logic             rst,
    smart_mac_ctrl_if.slave bus
);
    localparam int PW = CNT_W + 1;
    localparam logic [PW-1:0] EDGE_LOAD = PW'(load_cycles(NUM_MACS) - 1);
    localparam logic [PW-1:0] FEED_MIN  = PW'(NUM_MACS - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [NUM_MACS-1:0] top_q, top_d, route_q, route_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                feed_q, feed_d, op2_q, op2_d, outs_q, outs_d, stat_q, stat_d;
    logic [NUM_MACS-1:0] top_sel_q, top_sel_d, route_sel_q, route_sel_d;

    logic                cnt_load, cnt_dec, cnt_zero;
    logic [PW-1:0]       cnt_val, cnt_next, compute_last;

    // Widened so L + NUM_MACS - 2 never wraps, even for L = 2^CNT_W - 1.
    assign compute_last = PW'(compute_cycles(int'(len_q), NUM_MACS) - 1);

    smart_mac_ctrl_phase_counter #(.W(PW)) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_val   (cnt_val),
        .count_next (cnt_next),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        top_d    = top_q;
        route_d  = route_q;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    if (bus.cfg_len != '0) begin
                        state_d  = ST_LOAD;
                        len_d    = bus.cfg_len;
                        top_d    = bus.cfg_top_mask;
                        route_d  = bus.cfg_route_mask;
                        cnt_load = 1'b1;
                        cnt_val  = EDGE_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_LOAD: if (cnt_zero) begin
                    state_d  = ST_COMPUTE;
                    cnt_load = 1'b1;
                    cnt_val  = compute_last;
                end else cnt_dec = 1'b1;
                ST_COMPUTE: if (cnt_zero) begin
                    state_d  = ST_DRAIN;
                    cnt_load = 1'b1;
                    cnt_val  = EDGE_LOAD;
                end else cnt_dec = 1'b1;
                ST_DRAIN: if (cnt_zero) begin
                    state_d  = ST_DONE;
                    cnt_load = 1'b1;
                end else cnt_dec = 1'b1;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are valid in the same
    // cycle the FSM occupies that state.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        stat_d      = (state_d == ST_LOAD);
        op2_d       = (state_d == ST_COMPUTE);
        outs_d      = (state_d == ST_DRAIN);
        feed_d      = stat_d || (op2_d && (cnt_next >= FEED_MIN));
        top_sel_d   = (stat_d || op2_d) ? top_d : '0;
        route_sel_d = outs_d ? route_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            top_q       <= '0;
            route_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            feed_q      <= 1'b0;
            op2_q       <= 1'b0;
            outs_q      <= 1'b0;
            stat_q      <= 1'b0;
            top_sel_q   <= '0;
            route_sel_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            top_q       <= top_d;
            route_q     <= route_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            feed_q      <= feed_d;
            op2_q       <= op2_d;
            outs_q      <= outs_d;
            stat_q      <= stat_d;
            top_sel_q   <= top_sel_d;
            route_sel_q <= route_sel_d;
        end
    end

    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;
    assign bus.err                    = err_q;
    assign bus.feed_en                = feed_q;
    assign bus.fsm_op2_select         = op2_q;
    assign bus.fsm_out_select         = outs_q;
    assign bus.stat_bit               = stat_q;
    assign bus.select_top_in_smart    = top_sel_q;
    assign bus.select_right_out_smart = route_sel_q;
endmodule

// File: tb/tb_smart_mac_ctrl.sv
// Scoreboard bench for smart_mac_ctrl: a job-level model expands each accepted
// job into its expected per-cycle output sequence; a monitor compares every cycle.
module tb_smart_mac_ctrl;
    localparam int N  = 4;
    localparam int CW = 8;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         err;
        logic         feed;
        logic         op2;
        logic         outs;
        logic         stat;
        logic [N-1:0] top;
        logic [N-1:0] route;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    smart_mac_ctrl_if #(.NUM_MACS(N), .CNT_W(CW)) bus ();

    smart_mac_ctrl #(.NUM_MACS(N), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t plan[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   cur_busy = 1'b0;

    // Expand one job into its cycle-by-cycle expected outputs.
    task automatic build_job(input int len, input logic [N-1:0] top, input logic [N-1:0] route);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e = '0; e.busy = 1; e.stat = 1; e.feed = 1; e.top = top;
            plan.push_back(e);
        end
        for (int i = 0; i < len + N - 1; i++) begin
            e = '0; e.busy = 1; e.op2 = 1; e.feed = (i < len); e.top = top;
            plan.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            e = '0; e.busy = 1; e.outs = 1; e.route = route;
            plan.push_back(e);
        end
        e = '0; e.busy = 1; e.done = 1;
        plan.push_back(e);
    endtask

    // Drive one cycle of inputs and record the outputs expected after the next edge.
    task automatic step(input bit r, input bit s, input bit a, input int len,
                        input logic [N-1:0] top, input logic [N-1:0] route);
        exp_t e;
        rst                = r;
        bus.start          = s;
        bus.abort          = a;
        bus.cfg_len        = CW'(len);
        bus.cfg_top_mask   = top;
        bus.cfg_route_mask = route;
        e = '0;
        if (r) begin
            plan.delete();
        end else if (a && cur_busy) begin
            plan.delete();
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
        end else if (!cur_busy && s) begin
            if (len != 0) begin
                build_job(len, top, route);
                e = plan.pop_front();
            end else begin
                e.err = 1;
            end
        end
        cur_busy = e.busy;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, int'($urandom_range(0, 255)), N'($urandom), N'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {bus.busy, bus.done, bus.err, bus.feed_en, bus.fsm_op2_select,
                       bus.fsm_out_select, bus.stat_bit, bus.select_top_in_smart,
                       bus.select_right_out_smart};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got busy=%b done=%b err=%b feed=%b op2=%b outs=%b stat=%b top=%b route=%b, required busy=%b done=%b err=%b feed=%b op2=%b outs=%b stat=%b top=%b route=%b",
                             $time, got.busy, got.done, got.err, got.feed, got.op2, got.outs,
                             got.stat, got.top, got.route, e.busy, e.done, e.err, e.feed,
                             e.op2, e.outs, e.stat, e.top, e.route);
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, '0);

        // Basic job, L=3.
        step(0, 1, 0, 3, 4'b0010, 4'b1000);
        idle(18);

        // Zero-length start is rejected.
        step(0, 1, 0, 0, 4'b1111, 4'b1111);
        idle(3);

        // Start during COMPUTE is ignored.
        step(0, 1, 0, 5, 4'b0101, 4'b0011);
        idle(6);
        step(0, 1, 0, 7, 4'b1111, 4'b1111);
        idle(18);

        // Abort in the second DRAIN cycle, then immediate restart.
        step(0, 1, 0, 3, 4'b0110, 4'b1001);
        idle(11);
        step(0, 0, 1, 9, 4'b1111, 4'b1111);
        step(0, 1, 0, 2, 4'b1100, 4'b0001);
        idle(16);

        // Abort and start together in IDLE: start wins.
        step(0, 1, 1, 1, 4'b0001, 4'b0010);
        idle(12);

        // Reset during LOAD, then the basic job again.
        step(0, 1, 0, 3, 4'b1010, 4'b0101);
        idle(1);
        step(1, 0, 0, 0, '0, '0);
        idle(1);
        step(0, 1, 0, 3, 4'b0010, 4'b1000);
        idle(18);

        // Maximum length.
        step(0, 1, 0, 255, 4'b1001, 4'b0110);
        idle(270);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12)),
                 N'($urandom), N'($urandom));
        end
        idle(2);

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
